// File: rtl/bram_arbiter.sv
// Two-port (fetch/LSU) initiator for a single-port bram request/ready bus.
// Buffers one request per port, round-robins on ties and times out silent responders.
module bram_arbiter #(
  parameter int unsigned TIMEOUT    = 16,
  parameter bit          FIRST_DATA = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_rdata_o,
  output logic        imem_ready_o,
  output logic        imem_error_o,
  input  logic        dmem_valid_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_wstrb_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_ready_o,
  output logic        dmem_error_o,
  output logic        bram_valid_o,
  output logic        bram_instr_o,
  output logic [31:0] bram_addr_o,
  output logic [31:0] bram_wdata_o,
  output logic [3:0]  bram_wstrb_o,
  input  logic [31:0] bram_rdata_i,
  input  logic        bram_ready_i
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          i_full_q, i_full_d;
  logic [AW-1:0] i_addr_q, i_addr_d;
  logic          d_full_q, d_full_d;
  req_t          d_req_q, d_req_d;
  logic          owner_q, owner_d;   // 1 = data port owns the bus
  logic          rr_q, rr_d;         // 1 = data port wins the next tie
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bram_valid_q, bram_valid_d;
  logic          bram_instr_q, bram_instr_d;
  req_t          bram_req_q, bram_req_d;

  logic in_wait, hit_end, done, tmo;
  logic i_busy, d_busy, can_issue, grant, pick_d;

  // Completion decode; a new grant may issue on the same edge that completes.
  always_comb begin
    in_wait   = (state_q == ST_WAIT);
    hit_end   = (cnt_q == CW'(TIMEOUT - 1));
    done      = in_wait && (bram_ready_i || hit_end);
    tmo       = in_wait && !bram_ready_i && hit_end;
    i_busy    = in_wait && !owner_q && !done;
    d_busy    = in_wait && owner_q && !done;
    can_issue = !in_wait || done;
    grant     = can_issue && (i_full_q || d_full_q);
    pick_d    = d_full_q && (!i_full_q || rr_q);
  end

  // Next-state: grant/complete/count, then slot captures.
  always_comb begin
    state_d      = state_q;
    i_full_d     = i_full_q;
    i_addr_d     = i_addr_q;
    d_full_d     = d_full_q;
    d_req_d      = d_req_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    bram_valid_d = 1'b0;
    bram_instr_d = bram_instr_q;
    bram_req_d   = bram_req_q;

    if (grant) begin
      bram_valid_d = 1'b1;
      bram_instr_d = !pick_d;
      owner_d      = pick_d;
      rr_d         = !pick_d;
      cnt_d        = '0;
      state_d      = ST_WAIT;
      if (pick_d) begin
        bram_req_d = d_req_q;
        d_full_d   = 1'b0;
      end else begin
        bram_req_d.addr  = i_addr_q;
        bram_req_d.wdata = '0;
        bram_req_d.wstrb = '0;
        i_full_d         = 1'b0;
      end
    end else if (done) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (in_wait) begin
      cnt_d = cnt_q + CW'(1);
    end

    // Requests while the slot is full or the port is still outstanding are dropped.
    if (imem_valid_i && !i_full_q && !i_busy) begin
      i_full_d = 1'b1;
      i_addr_d = imem_addr_i;
    end
    if (dmem_valid_i && !d_full_q && !d_busy) begin
      d_full_d      = 1'b1;
      d_req_d.addr  = dmem_addr_i;
      d_req_d.wdata = dmem_wdata_i;
      d_req_d.wstrb = dmem_wstrb_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      i_full_q     <= 1'b0;
      i_addr_q     <= '0;
      d_full_q     <= 1'b0;
      d_req_q      <= '0;
      owner_q      <= 1'b0;
      rr_q         <= FIRST_DATA;
      cnt_q        <= '0;
      bram_valid_q <= 1'b0;
      bram_instr_q <= 1'b0;
      bram_req_q   <= '0;
    end else begin
      state_q      <= state_d;
      i_full_q     <= i_full_d;
      i_addr_q     <= i_addr_d;
      d_full_q     <= d_full_d;
      d_req_q      <= d_req_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      bram_valid_q <= bram_valid_d;
      bram_instr_q <= bram_instr_d;
      bram_req_q   <= bram_req_d;
    end
  end

  // Same-cycle completion back to the owning port; timeouts return zero data.
  always_comb begin
    imem_ready_o = done && !owner_q;
    dmem_ready_o = done && owner_q;
    imem_error_o = tmo && !owner_q;
    dmem_error_o = tmo && owner_q;
    imem_rdata_o = (done && !owner_q && !tmo) ? bram_rdata_i : '0;
    dmem_rdata_o = (done && owner_q && !tmo) ? bram_rdata_i : '0;
  end

  assign bram_valid_o = bram_valid_q;
  assign bram_instr_o = bram_instr_q;
  assign bram_addr_o  = bram_req_q.addr;
  assign bram_wdata_o = bram_req_q.wdata;
  assign bram_wstrb_o = bram_req_q.wstrb;

endmodule
